// File: rtl/alu_issue_queue.sv
// In-order ALU issue queue: buffers dispatched micro-ops, wakes sources from the result bus and issues the head through a registered stage.
// Optional: define ALU_IQ_BYPASS_EN so that a head woken this cycle issues in the same cycle, using the result-bus data.
module alu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int MICOP_W = 8,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 2
) (
  input  logic                       Clk,
  input  logic                       Rest,
  input  logic                       Flush,
  input  logic                       DispValid,
  output logic                       DispReady,
  input  logic [MICOP_W-1:0]         DispMicOperate,
  input  logic [DATA_W-1:0]          DispSrc1Data,
  input  logic [REG_W-1:0]           DispSrc1Tag,
  input  logic [CNT_W-1:0]           DispSrc1Cnt,
  input  logic [DATA_W-1:0]          DispSrc2Data,
  input  logic [REG_W-1:0]           DispSrc2Tag,
  input  logic [CNT_W-1:0]           DispSrc2Cnt,
  input  logic [REG_W-1:0]           DispDestAddr,
  input  logic                       DispIsQInst,
  input  logic                       WbValid,
  input  logic [REG_W-1:0]           WbAddr,
  input  logic [DATA_W-1:0]          WbData,
  output logic                       IssueValid,
  output logic [MICOP_W-1:0]         IssueMicOperate,
  output logic [DATA_W-1:0]          IssueReg1,
  output logic [DATA_W-1:0]          IssueReg2,
  output logic [REG_W-1:0]           IssueDestAddr,
  output logic                       IssueIsQInst,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0]   ent_valid;
  logic [MICOP_W-1:0] ent_micop  [DEPTH];
  logic [DATA_W-1:0]  ent_s1data [DEPTH];
  logic [REG_W-1:0]   ent_s1tag  [DEPTH];
  logic [CNT_W-1:0]   ent_s1cnt  [DEPTH];
  logic [DATA_W-1:0]  ent_s2data [DEPTH];
  logic [REG_W-1:0]   ent_s2tag  [DEPTH];
  logic [CNT_W-1:0]   ent_s2cnt  [DEPTH];
  logic [REG_W-1:0]   ent_dest   [DEPTH];
  logic               ent_isq    [DEPTH];

  logic [DATA_W-1:0]  wk_s1data [DEPTH];
  logic [CNT_W-1:0]   wk_s1cnt  [DEPTH];
  logic [DATA_W-1:0]  wk_s2data [DEPTH];
  logic [CNT_W-1:0]   wk_s2cnt  [DEPTH];

  logic [DATA_W-1:0]  in_s1data, in_s2data;
  logic [CNT_W-1:0]   in_s1cnt, in_s2cnt;

  logic [PTR_W-1:0]   head, tail;
  logic               wb_fire, push, pop, head_ready;

  // Register r0 is always ready with value zero; otherwise a matching broadcast
  // decrements the producer count and the final producer supplies the data.
  function automatic logic [CNT_W+DATA_W-1:0] wake_src(
    input logic [REG_W-1:0]  tag,
    input logic [CNT_W-1:0]  cnt,
    input logic [DATA_W-1:0] data,
    input logic              fire,
    input logic [REG_W-1:0]  addr,
    input logic [DATA_W-1:0] wdata
  );
    logic [CNT_W-1:0]  c;
    logic [DATA_W-1:0] d;
    c = cnt;
    d = data;
    if (tag == '0) begin
      c = '0;
      d = '0;
    end else if (fire && (tag == addr) && (cnt != '0)) begin
      c = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) d = wdata;
    end
    return {c, d};
  endfunction

  assign wb_fire   = WbValid && (WbAddr != '0);
  assign DispReady = (Count < FULL_CNT) && !Flush;
  assign push      = DispValid && DispReady;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wk_s1cnt[i], wk_s1data[i]} = wake_src(ent_s1tag[i], ent_s1cnt[i], ent_s1data[i], wb_fire, WbAddr, WbData);
      {wk_s2cnt[i], wk_s2data[i]} = wake_src(ent_s2tag[i], ent_s2cnt[i], ent_s2data[i], wb_fire, WbAddr, WbData);
    end
    {in_s1cnt, in_s1data} = wake_src(DispSrc1Tag, DispSrc1Cnt, DispSrc1Data, wb_fire, WbAddr, WbData);
    {in_s2cnt, in_s2data} = wake_src(DispSrc2Tag, DispSrc2Cnt, DispSrc2Data, wb_fire, WbAddr, WbData);
  end

`ifdef ALU_IQ_BYPASS_EN
  assign head_ready = (wk_s1cnt[head] == '0) && (wk_s2cnt[head] == '0);
`else
  assign head_ready = (ent_s1cnt[head] == '0) && (ent_s2cnt[head] == '0);
`endif

  assign pop = ent_valid[head] && head_ready && !Flush;

  // Woken data is used for issue in both builds; without bypass a ready head has
  // no pending sources, so the woken view equals the stored one.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      ent_valid       <= '0;
      head            <= '0;
      tail            <= '0;
      Count           <= '0;
      IssueValid      <= 1'b0;
      IssueMicOperate <= '0;
      IssueReg1       <= '0;
      IssueReg2       <= '0;
      IssueDestAddr   <= '0;
      IssueIsQInst    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_micop[i]  <= '0;
        ent_s1data[i] <= '0;
        ent_s1tag[i]  <= '0;
        ent_s1cnt[i]  <= '0;
        ent_s2data[i] <= '0;
        ent_s2tag[i]  <= '0;
        ent_s2cnt[i]  <= '0;
        ent_dest[i]   <= '0;
        ent_isq[i]    <= 1'b0;
      end
    end else if (Flush) begin
      ent_valid  <= '0;
      head       <= '0;
      tail       <= '0;
      Count      <= '0;
      IssueValid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i]) begin
          ent_s1cnt[i]  <= wk_s1cnt[i];
          ent_s1data[i] <= wk_s1data[i];
          ent_s2cnt[i]  <= wk_s2cnt[i];
          ent_s2data[i] <= wk_s2data[i];
        end
      end
      if (push) begin
        ent_valid[tail]  <= 1'b1;
        ent_micop[tail]  <= DispMicOperate;
        ent_s1data[tail] <= in_s1data;
        ent_s1tag[tail]  <= DispSrc1Tag;
        ent_s1cnt[tail]  <= in_s1cnt;
        ent_s2data[tail] <= in_s2data;
        ent_s2tag[tail]  <= DispSrc2Tag;
        ent_s2cnt[tail]  <= in_s2cnt;
        ent_dest[tail]   <= DispDestAddr;
        ent_isq[tail]    <= DispIsQInst;
        tail             <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
        IssueMicOperate <= ent_micop[head];
        IssueReg1       <= wk_s1data[head];
        IssueReg2       <= wk_s2data[head];
        IssueDestAddr   <= ent_dest[head];
        IssueIsQInst    <= ent_isq[head];
      end
      IssueValid <= pop;
      if (push && !pop)      Count <= Count + CW'(1);
      else if (pop && !push) Count <= Count - CW'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue; expectations follow ALU_IQ_BYPASS_EN when it is defined.
module tb_alu_issue_queue;

  logic        Clk, Rest, Flush;
  logic        DispValid, DispReady;
  logic [7:0]  DispMicOperate;
  logic [31:0] DispSrc1Data, DispSrc2Data;
  logic [4:0]  DispSrc1Tag, DispSrc2Tag;
  logic [1:0]  DispSrc1Cnt, DispSrc2Cnt;
  logic [4:0]  DispDestAddr;
  logic        DispIsQInst;
  logic        WbValid;
  logic [4:0]  WbAddr;
  logic [31:0] WbData;
  logic        IssueValid;
  logic [7:0]  IssueMicOperate;
  logic [31:0] IssueReg1, IssueReg2;
  logic [4:0]  IssueDestAddr;
  logic        IssueIsQInst;
  logic [2:0]  Count;

  int checks = 0;
  int fails  = 0;

  alu_issue_queue #(.DEPTH(4), .DATA_W(32), .MICOP_W(8), .REG_W(5), .CNT_W(2)) dut (
    .Clk(Clk), .Rest(Rest), .Flush(Flush),
    .DispValid(DispValid), .DispReady(DispReady), .DispMicOperate(DispMicOperate),
    .DispSrc1Data(DispSrc1Data), .DispSrc1Tag(DispSrc1Tag), .DispSrc1Cnt(DispSrc1Cnt),
    .DispSrc2Data(DispSrc2Data), .DispSrc2Tag(DispSrc2Tag), .DispSrc2Cnt(DispSrc2Cnt),
    .DispDestAddr(DispDestAddr), .DispIsQInst(DispIsQInst),
    .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData),
    .IssueValid(IssueValid), .IssueMicOperate(IssueMicOperate),
    .IssueReg1(IssueReg1), .IssueReg2(IssueReg2), .IssueDestAddr(IssueDestAddr),
    .IssueIsQInst(IssueIsQInst), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    Flush = 0; DispValid = 0; DispMicOperate = 0; DispSrc1Data = 0; DispSrc1Tag = 0; DispSrc1Cnt = 0;
    DispSrc2Data = 0; DispSrc2Tag = 0; DispSrc2Cnt = 0; DispDestAddr = 0; DispIsQInst = 0;
    WbValid = 0; WbAddr = 0; WbData = 0;
  endtask

  task automatic drive_op(input logic [7:0] mop, input logic [31:0] d1, input logic [4:0] t1, input logic [1:0] c1,
                          input logic [31:0] d2, input logic [4:0] t2, input logic [1:0] c2, input logic [4:0] dst);
    DispValid = 1; DispMicOperate = mop; DispSrc1Data = d1; DispSrc1Tag = t1; DispSrc1Cnt = c1;
    DispSrc2Data = d2; DispSrc2Tag = t2; DispSrc2Cnt = c2; DispDestAddr = dst; DispIsQInst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Rest = 0;
    repeat (2) @(negedge Clk);
    checks++; if (Count !== 3'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", Count); end
    checks++; if (IssueValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", IssueValid); end
    checks++; if ({IssueReg1, IssueReg2, IssueDestAddr, IssueMicOperate} !== '0) begin fails++; $display("[TB] FAIL reset_data: got %h/%h/%h/%h expected 0", IssueReg1, IssueReg2, IssueDestAddr, IssueMicOperate); end
    Rest = 1;
    #1;
    checks++; if (DispReady !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", DispReady); end
    cycle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      drive_op(8'h01, 32'd5, 5'd1, 2'd0, 32'd7, 5'd2, 2'd0, 5'd3);
      checks++; if (DispReady !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready%0d: got %b expected 1", k, DispReady); end
      cycle();
      checks++; if (Count !== 3'd1) begin fails++; $display("[TB] FAIL b2b_count%0d: got %0d expected 1", k, Count); end
      checks++; if (IssueValid !== (k > 0)) begin fails++; $display("[TB] FAIL b2b_valid%0d: got %b expected %b", k, IssueValid, k > 0); end
    end
    idle_inputs();
    cycle();
    checks++; if (IssueValid !== 1'b1 || Count !== 3'd0) begin fails++; $display("[TB] FAIL b2b_last: got valid %b count %0d expected 1 0", IssueValid, Count); end
    checks++; if (IssueReg1 !== 32'd5 || IssueReg2 !== 32'd7 || IssueDestAddr !== 5'd3 || IssueMicOperate !== 8'h01) begin
      fails++; $display("[TB] FAIL b2b_data: got %0d %0d %0d %h expected 5 7 3 01", IssueReg1, IssueReg2, IssueDestAddr, IssueMicOperate); end
    cycle();
    checks++; if (IssueValid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_idle: got %b expected 0", IssueValid); end
  endtask

  task automatic test_full();
    logic [31:0] exp_r1 [4];
    int issued;
    exp_r1[0] = 32'h33; exp_r1[1] = 32'h41; exp_r1[2] = 32'h42; exp_r1[3] = 32'h43;
    drive_op(8'h02, 32'h0, 5'd10, 2'd1, 32'd1, 5'd2, 2'd0, 5'd4);
    cycle();
    for (int k = 1; k < 4; k++) begin
      drive_op(8'h02, 32'h40 + k, 5'd1, 2'd0, 32'd1, 5'd2, 2'd0, 5'd4);
      cycle();
    end
    checks++; if (Count !== 3'd4 || DispReady !== 1'b0) begin fails++; $display("[TB] FAIL full_state: got count %0d ready %b expected 4 0", Count, DispReady); end
    drive_op(8'h02, 32'h99, 5'd1, 2'd0, 32'd1, 5'd2, 2'd0, 5'd4);
    cycle();
    checks++; if (Count !== 3'd4 || IssueValid !== 1'b0) begin fails++; $display("[TB] FAIL full_refuse: got count %0d valid %b expected 4 0", Count, IssueValid); end
    idle_inputs();
    WbValid = 1; WbAddr = 5'd10; WbData = 32'h33;
    issued = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      WbValid = 0;
      if (IssueValid === 1'b1) begin
        if (issued < 4) begin
          checks++; if (IssueReg1 !== exp_r1[issued]) begin fails++; $display("[TB] FAIL full_order%0d: got %h expected %h", issued, IssueReg1, exp_r1[issued]); end
        end
        issued++;
      end
    end
    checks++; if (issued !== 4 || Count !== 3'd0) begin fails++; $display("[TB] FAIL full_drain: got %0d issues count %0d expected 4 0", issued, Count); end
  endtask

  task automatic test_wakeup();
    drive_op(8'h03, 32'hDEAD, 5'd6, 2'd2, 32'h99, 5'd4, 2'd0, 5'd5);
    cycle();
    idle_inputs();
    WbValid = 1; WbAddr = 5'd6; WbData = 32'h11;
    cycle();
    checks++; if (IssueValid !== 1'b0) begin fails++; $display("[TB] FAIL wake_first: got %b expected 0", IssueValid); end
    WbData = 32'h22;
    cycle();
    WbValid = 0;
`ifndef ALU_IQ_BYPASS_EN
    checks++; if (IssueValid !== 1'b0) begin fails++; $display("[TB] FAIL wake_nobypass_wait: got %b expected 0", IssueValid); end
    cycle();
`endif
    checks++; if (IssueValid !== 1'b1 || IssueReg1 !== 32'h22 || IssueReg2 !== 32'h99) begin
      fails++; $display("[TB] FAIL wake_issue: got valid %b r1 %h r2 %h expected 1 22 99", IssueValid, IssueReg1, IssueReg2); end
    cycle();
  endtask

  task automatic test_r0();
    drive_op(8'h04, 32'd5, 5'd3, 2'd0, 32'h77, 5'd0, 2'd1, 5'd4);
    cycle();
    idle_inputs();
    cycle();
    checks++; if (IssueValid !== 1'b1 || IssueReg2 !== 32'd0 || IssueReg1 !== 32'd5) begin
      fails++; $display("[TB] FAIL r0_issue: got valid %b r1 %h r2 %h expected 1 5 0", IssueValid, IssueReg1, IssueReg2); end
    cycle();
  endtask

  task automatic test_flush();
    int seen;
    drive_op(8'h05, 32'h0, 5'd12, 2'd1, 32'd0, 5'd0, 2'd0, 5'd7);
    cycle();
    drive_op(8'h05, 32'h1, 5'd1, 2'd0, 32'd0, 5'd0, 2'd0, 5'd8);
    cycle();
    checks++; if (Count !== 3'd2) begin fails++; $display("[TB] FAIL flush_pre: got %0d expected 2", Count); end
    drive_op(8'h05, 32'h2, 5'd1, 2'd0, 32'd0, 5'd0, 2'd0, 5'd9);
    Flush = 1; WbValid = 1; WbAddr = 5'd12; WbData = 32'h55;
    #1;
    checks++; if (DispReady !== 1'b0) begin fails++; $display("[TB] FAIL flush_ready: got %b expected 0", DispReady); end
    cycle();
    checks++; if (Count !== 3'd0 || IssueValid !== 1'b0 || IssueDestAddr !== 5'd4) begin
      fails++; $display("[TB] FAIL flush_state: got count %0d valid %b dest %0d expected 0 0 4", Count, IssueValid, IssueDestAddr); end
    idle_inputs();
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (IssueValid === 1'b1) seen++;
    end
    checks++; if (seen !== 0 || Count !== 3'd0) begin fails++; $display("[TB] FAIL flush_after: got %0d issues count %0d expected 0 0", seen, Count); end
  endtask

  task automatic test_bypass();
    drive_op(8'h06, 32'h0, 5'd9, 2'd1, 32'h3, 5'd0, 2'd0, 5'd2);
    cycle();
    idle_inputs();
    WbValid = 1; WbAddr = 5'd9; WbData = 32'hA5;
    cycle();
    WbValid = 0;
`ifndef ALU_IQ_BYPASS_EN
    checks++; if (IssueValid !== 1'b0) begin fails++; $display("[TB] FAIL bypass_wait: got %b expected 0", IssueValid); end
    cycle();
`endif
    checks++; if (IssueValid !== 1'b1 || IssueReg1 !== 32'hA5 || IssueDestAddr !== 5'd2) begin
      fails++; $display("[TB] FAIL bypass_issue: got valid %b r1 %h dest %0d expected 1 a5 2", IssueValid, IssueReg1, IssueDestAddr); end
    cycle();
    checks++; if (IssueValid !== 1'b0) begin fails++; $display("[TB] FAIL bypass_single: got %b expected 0", IssueValid); end
  endtask

  task automatic test_reset_midstream();
    int waited;
    drive_op(8'h07, 32'h0, 5'd20, 2'd1, 32'h0, 5'd0, 2'd0, 5'd1);
    cycle();
    for (int k = 1; k < 4; k++) begin
      drive_op(8'h07, 32'h10 + k, 5'd1, 2'd0, 32'h0, 5'd0, 2'd0, 5'd1);
      cycle();
    end
    idle_inputs();
    WbValid = 1; WbAddr = 5'd20; WbData = 32'h66;
    waited = 0;
    while (IssueValid !== 1'b1 && waited < 5) begin
      cycle();
      WbValid = 0;
      waited++;
    end
    checks++; if (IssueValid !== 1'b1 || Count !== 3'd3) begin fails++; $display("[TB] FAIL mid_pre: got valid %b count %0d expected 1 3", IssueValid, Count); end
    #2 Rest = 0;
    #1;
    checks++; if (IssueValid !== 1'b0 || Count !== 3'd0) begin fails++; $display("[TB] FAIL mid_async: got valid %b count %0d expected 0 0", IssueValid, Count); end
    @(negedge Clk);
    Rest = 1;
    #1;
    checks++; if (DispReady !== 1'b1) begin fails++; $display("[TB] FAIL mid_release: got %b expected 1", DispReady); end
    cycle();
    cycle();
    checks++; if (IssueValid !== 1'b0 || Count !== 3'd0) begin fails++; $display("[TB] FAIL mid_after: got valid %b count %0d expected 0 0", IssueValid, Count); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_wakeup();
    test_r0();
    test_flush();
    test_bypass();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
